// File: rtl/lsu_pkg.sv
// Shared load/store definitions: access size codes (also used by the main decoder),
// FSM states, byte strobes and the size/lane helper functions.
package lsu_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    // Access captured when the unit leaves IDLE; drives the bus until the access retires.
    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [1:0]  off;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } lsu_req_t;

    // Stores only honour the low two bits; unknown codes fall back to a signed byte.
    function automatic logic [2:0] norm_size(input logic [2:0] s, input logic st);
        logic [2:0] n;
        n = st ? {1'b0, s[1:0]} : s;
        case (n)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: return n;
            default:                        return SZ_B;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] s, input logic [1:0] off);
        case (s)
            SZ_H, SZ_HU: return off[0];
            SZ_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] strb_of(input logic [2:0] s, input logic [1:0] off);
        case (s)
            SZ_H:    return STRB_H << {off[1], 1'b0};
            SZ_W:    return STRB_W;
            default: return STRB_B << off;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] s, input logic [31:0] d);
        case (s)
            SZ_H:    return {2{d[15:0]}};
            SZ_W:    return d;
            default: return {4{d[7:0]}};
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Picks the addressed byte/half out of a raw read word and sign- or zero-extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    output logic [31:0] ext
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b   = word[{off, 3'b000} +: 8];
        h   = off[1] ? word[31:16] : word[15:0];
        ext = {{24{b[7]}}, b};
        case (size)
            SZ_H:    ext = {{16{h[15]}}, h};
            SZ_W:    ext = word;
            SZ_BU:   ext = {24'b0, b};
            SZ_HU:   ext = {16'b0, h};
            default: ext = {{24{b[7]}}, b};
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one word-wide req/gnt/rvalid access per instruction,
// stalling the pipeline until it retires, with misalignment and timeout reporting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memWrite,
    input  logic              memRead,
    input  logic [2:0]        sizeSrc,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misalign_err,
    output logic              bus_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_t        state, state_nxt;
    lsu_req_t          cur;
    logic [ADDR_W-1:0] cur_addr;
    logic [CW-1:0]     cnt;
    logic [2:0]        sz;
    logic [31:0]       ext;
    logic              berr, tmo, tmo_fire, req_in, mis, accept;

    assign sz     = norm_size(sizeSrc, memWrite);
    assign req_in = memRead | memWrite;
    assign mis    = misaligned(sz, addr[1:0]);
    assign accept = (state == IDLE) && req_in && !mis;
    // cnt counts cycles spent in the current REQ/WAIT visit; tmo marks its last allowed cycle
    assign tmo    = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    load_extend u_ext (.word(mem_rdata), .off(cur.off), .size(cur.size), .ext(ext));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        tmo_fire     = 1'b0;
        mem_req      = 1'b0;
        stall        = 1'b0;
        rdata_valid  = 1'b0;
        misalign_err = 1'b0;
        case (state)
            IDLE: begin
                stall        = accept;
                misalign_err = req_in && mis;
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                // a same-cycle rvalid is deliberately ignored here
                if (mem_gnt)  state_nxt = cur.we ? DONE : WAIT;
                else if (tmo) begin
                    tmo_fire  = 1'b1;
                    state_nxt = DONE;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) state_nxt = DONE;
                else if (tmo) begin
                    tmo_fire  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rdata_valid = !cur.we;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            mem_req      = 1'b0;
            stall        = 1'b0;
            rdata_valid  = 1'b0;
            misalign_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            berr     <= 1'b0;
            rdata    <= '0;
            cur      <= '0;
            cur_addr <= '0;
        end else begin
            berr <= tmo_fire;
            if (state != state_nxt)                   cnt <= '0;
            else if (state == REQ || state == WAIT)   cnt <= cnt + CW'(1);
            if (accept) begin
                cur      <= '{we:    memWrite,
                              size:  sz,
                              off:   addr[1:0],
                              strb:  memWrite ? strb_of(sz, addr[1:0]) : STRB_NONE,
                              wdata: wdata_of(sz, wdata)};
                cur_addr <= {addr[ADDR_W-1:2], 2'b00};
            end
            if (state == WAIT) begin
                if (mem_rvalid) rdata <= ext;
                else if (tmo)   rdata <= '0;
            end
        end
    end

    assign mem_we    = mem_req & cur.we;
    assign mem_addr  = cur_addr;
    assign mem_wstrb = mem_req ? cur.strb : STRB_NONE;
    assign mem_wdata = cur.wdata;
    assign bus_err   = berr;

endmodule
